// File: rtl/display_pkg.sv
// Shared display definitions: blank levels, scan phase encoding and active-low 7-segment glyphs.
// Glyph bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package display_pkg;

  localparam logic [63:0] SEG_OFF = '1;
  localparam logic [63:0] AN_OFF  = '1;

  typedef enum logic {PH_GUARD, PH_DRIVE} phase_e;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_H = 7'h09;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_L = 7'h47;
  localparam logic [6:0] GLYPH_S = 7'h12;
  localparam logic [6:0] GLYPH_O = 7'h40;
  localparam logic [6:0] GLYPH_F = 7'h0E;
  localparam logic [6:0] GLYPH_U = 7'h41;
  localparam logic [6:0] GLYPH_D = 7'h21;

endpackage

// File: rtl/display_scan_mux_if.sv
// Source-side bus (requests, segment data, blink masks) and pin-side scan outputs of the display mux.
// master = mode/time logic side, slave = the scan mux.
interface display_scan_mux_if #(
  parameter int N_SRC  = 5,
  parameter int DIGITS = 8,
  parameter int SEG_W  = 7
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]              src_req;
  logic [N_SRC*DIGITS*SEG_W-1:0] src_seg;
  logic [N_SRC*DIGITS-1:0]       src_blink;
  logic [DIGITS-1:0]             an;
  logic [SEG_W-1:0]              seg;
  logic [SRC_W-1:0]              active_src;
  logic                          src_valid;
  logic                          frame_tick;

  modport master (
    output src_req, src_seg, src_blink,
    input  an, seg, active_src, src_valid, frame_tick
  );

  modport slave (
    input  src_req, src_seg, src_blink,
    output an, seg, active_src, src_valid, frame_tick
  );
endinterface

// File: rtl/display_scan_mux_prio.sv
// Fixed-priority encoder: lowest set request index wins; o_any flags that any request is set.
// Purely combinational.
module prio_encoder #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/display_scan_mux.sv
// Priority-selects a display source once per frame and time-multiplexes its digits onto one
// active-low anode/segment bus with guard blanking and per-digit blink; outputs lag state by one cycle.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_SRC        = 5,
  parameter int DIGITS       = 8,
  parameter int SEG_W        = 7,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  display_scan_mux_if.slave bus
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IW    = $clog2(DIGITS);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  phase_e            r_phase;
  logic [SRC_W-1:0]  r_active;
  logic              r_valid;
  logic              r_frame_tick;
  logic [BW-1:0]     r_blink_cnt;
  logic              r_blink_ph;
  logic [DIGITS-1:0] r_an;
  logic [SEG_W-1:0]  r_seg;

  logic              w_digit_tick;
  logic              w_frame_end;
  logic [PW-1:0]     w_presc_nxt;
  logic [SRC_W-1:0]  w_sel_idx;
  logic              w_sel_any;
  logic [SEG_W-1:0]  w_cur_seg;
  logic              w_cur_blink;
  logic              w_blank;
  logic [DIGITS-1:0] w_an_on;

  prio_encoder #(.N(N_SRC), .IDX_W(SRC_W)) u_prio (
    .i_req (bus.src_req),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

  assign w_digit_tick = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_frame_end  = w_digit_tick && (r_idx == IW'(DIGITS - 1));
  assign w_presc_nxt  = w_digit_tick ? '0 : r_presc + PW'(1);

  // Segment data and blink mask are read live; only the source choice is frame-latched.
  always_comb begin
    w_cur_seg   = SEG_OFF[SEG_W-1:0];
    w_cur_blink = 1'b0;
    for (int s = 0; s < N_SRC; s++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (r_active == SRC_W'(s) && r_idx == IW'(d)) begin
          w_cur_seg   = bus.src_seg[(s*DIGITS+d)*SEG_W +: SEG_W];
          w_cur_blink = bus.src_blink[s*DIGITS+d];
        end
      end
    end
  end

  assign w_blank = (r_phase == PH_GUARD) || !r_valid || (w_cur_blink && r_blink_ph);
  assign w_an_on = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_phase      <= PH_GUARD;
      r_active     <= '0;
      r_valid      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_blink_cnt  <= '0;
      r_blink_ph   <= 1'b0;
      r_an         <= AN_OFF[DIGITS-1:0];
      r_seg        <= SEG_OFF[SEG_W-1:0];
    end else begin
      r_presc <= w_presc_nxt;

      case (r_phase)
        PH_GUARD: if (w_presc_nxt == PW'(GUARD)) r_phase <= PH_DRIVE;
        PH_DRIVE: if (w_digit_tick) r_phase <= PH_GUARD;
        default:  r_phase <= PH_GUARD;
      endcase

      if (w_digit_tick) r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

      r_frame_tick <= w_frame_end;
      if (w_frame_end) begin
        r_active <= w_sel_idx;
        r_valid  <= w_sel_any;
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end

      r_an  <= w_blank ? AN_OFF[DIGITS-1:0]  : w_an_on;
      r_seg <= w_blank ? SEG_OFF[SEG_W-1:0] : w_cur_seg;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.active_src = r_active;
  assign bus.src_valid  = r_valid;
  assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenario sequence with random segment data, checked every
// cycle against a model driven by the cycle count since reset.
module tb_display_scan_mux;
  localparam int N_SRC  = 3;
  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int RD     = 4;
  localparam int GUARD  = 1;
  localparam int BF     = 2;
  localparam int FRAME  = DIGITS * RD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_mux_if #(.N_SRC(N_SRC), .DIGITS(DIGITS), .SEG_W(SEG_W)) dif ();

  display_scan_mux #(
    .N_SRC(N_SRC), .DIGITS(DIGITS), .SEG_W(SEG_W),
    .REFRESH_DIV(RD), .GUARD(GUARD), .BLINK_FRAMES(BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: cycles since reset, frame boundaries seen, latched selection.
  int t = 0;
  int k = 0;
  int m_active = 0;
  bit m_valid = 1'b0;
  logic [DIGITS-1:0] e_an = '1;
  logic [SEG_W-1:0]  e_seg = '1;
  bit e_ft = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    int p;
    int d;
    bit bph;
    bit blank;
    if (rst) begin
      t = 0; k = 0; m_active = 0; m_valid = 1'b0;
      e_an = '1; e_seg = '1; e_ft = 1'b0;
      return;
    end
    p   = t % RD;
    d   = (t / RD) % DIGITS;
    bph = ((k / BF) % 2) == 1;
    blank = (p < GUARD) || !m_valid || (dif.src_blink[m_active*DIGITS+d] && bph);
    e_an  = '1;
    e_seg = '1;
    if (!blank) begin
      e_an[d] = 1'b0;
      e_seg   = dif.src_seg[(m_active*DIGITS+d)*SEG_W +: SEG_W];
    end
    e_ft = (t % FRAME) == FRAME - 1;
    if (e_ft) begin
      m_valid  = |dif.src_req;
      m_active = 0;
      for (int s = N_SRC - 1; s >= 0; s--) if (dif.src_req[s]) m_active = s;
      k++;
    end
    t++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an",         32'(dif.an),         32'(e_an));
    check("seg",        32'(dif.seg),        32'(e_seg));
    check("frame_tick", 32'(dif.frame_tick), 32'(e_ft));
    check("active_src", 32'(dif.active_src), 32'(m_active));
    check("src_valid",  32'(dif.src_valid),  32'(m_valid));
    check("an_onehot",  32'($countones(~dif.an) <= 1), 32'(1));
  endtask

  task automatic new_seg();
    for (int i = 0; i < N_SRC*DIGITS; i++) dif.src_seg[i*SEG_W +: SEG_W] = 7'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      new_seg();
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    dif.src_req   = '0;
    dif.src_blink = '0;
    new_seg();
    run(3);

    // Single low-priority request; first frame blank, then the scan of source 2.
    dif.src_req = 3'b100;
    rst = 1'b0;
    run(3 * FRAME);

    // Mid-frame request change only lands at the next boundary.
    run(6);
    dif.src_req = 3'b110;
    run(FRAME - 6 + 2 * FRAME);

    // All sources requesting: source 0 wins.
    dif.src_req = 3'b111;
    run(2 * FRAME);

    // Blink on source 0 digit 1.
    dif.src_blink = 12'h002;
    run(8 * FRAME);

    // No requests: next frame entirely blank.
    dif.src_req   = 3'b000;
    dif.src_blink = '0;
    run(2 * FRAME);

    // Reset mid-frame at prescaler 2, digit 2.
    dif.src_req = 3'b010;
    run(FRAME);
    while ((t % FRAME) != 2 * RD + 2) run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3 * FRAME);

    // Random requests, blink masks and occasional resets.
    repeat (60) begin
      dif.src_req   = 3'($urandom);
      dif.src_blink = 12'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      run(1);
      rst = 1'b0;
      run($urandom_range(1, 40));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
